// File: rtl/x6ff_rr_sched_if.sv
// x6ff_rr_sched_if: channel-side and stream-side signals of the event-level
// round-robin scheduler. The master modport is the scheduler itself; the
// slave modport is the surrounding FIFO controllers / event builder.
interface x6ff_rr_sched_if #(
   parameter int NCH = 6,
   parameter int DW  = 32
);
   logic [NCH-1:0]    pok;       // per-channel word present on din
   logic [NCH*DW-1:0] din;       // flattened channel data, channel i at [i*DW +: DW]
   logic [NCH-1:0]    pop;       // one-hot single-cycle consume strobe
   logic [DW-1:0]     dout;      // registered merged word
   logic              dout_vld;  // dout holds a valid word
   logic              dout_rdy;  // downstream accepts dout
   logic [2:0]        dout_ch;   // channel that produced dout

   modport master (
      input  pok, din, dout_rdy,
      output pop, dout, dout_vld, dout_ch
   );

   modport slave (
      output pok, din, dout_rdy,
      input  pop, dout, dout_vld, dout_ch
   );
endinterface

// File: rtl/x6ff_rr_sched.sv
// x6ff_rr_sched: event-level round-robin scheduler for six FIFO read
// controllers. A channel is held from its first word until its end-of-event
// word (bit DW-1) has been transferred, or until MAXLEN words have gone by,
// so events from different FIFOs never interleave on the output stream.
// Optional per-channel completed-event counters (evcnt port) are built when
// the macro X6FF_RR_SCHED_STATS_EN is defined.
module x6ff_rr_sched #(
   parameter int NCH    = 6,
   parameter int DW     = 32,
   parameter int MAXLEN = 256,
   parameter int LW     = 9
) (
   input  logic            clk,
   input  logic            init_,
   x6ff_rr_sched_if.master bus,
   output logic            ovf,
   output logic            busy
`ifdef X6FF_RR_SCHED_STATS_EN
   ,
   output logic [NCH*16-1:0] evcnt
`endif
);

   localparam int CW = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [CW-1:0]   cur_reg, cur_next;
   logic [LW-1:0]   wcnt_reg, wcnt_next, wcnt_inc;
   logic            ovf_reg, ovf_next;
   logic [NCH-1:0]  blank_reg;

   logic [NCH-1:0]  eligible;
   logic [NCH-1:0]  pop_vec;
   logic            free;
   logic            hit;
   logic [CW-1:0]   hit_ch;
   logic [CW-1:0]   probe;
   logic [CW-1:0]   pop_ch;
   logic            pop_req;
   logic            pop_en;
   logic            pop_eoe;
   logic [DW-1:0]   pop_word;
   logic [DW-1:0]   din_arr [NCH];

   logic [DW-1:0]   dout_reg;
   logic            dout_vld_reg;
   logic [CW-1:0]   dout_ch_reg;

   // Channel index increment with wrap NCH-1 -> 0.
   function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
      if (c == CW'(NCH - 1)) begin
         return '0;
      end
      return c + 1'b1;
   endfunction

   // Unflatten the channel data bus so the selected word is a plain mux.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_din
         assign din_arr[gi] = bus.din[gi*DW +: DW];
      end
   endgenerate

   // A channel popped last cycle still shows its old pok, so it sits out one cycle.
   assign eligible = bus.pok & ~blank_reg;

   // The output register can take a new word when empty or being drained now.
   assign free = !dout_vld_reg || bus.dout_rdy;

   // Round-robin search: first eligible channel at or after rr_ptr, wrapping.
   always_comb begin
      hit    = 1'b0;
      hit_ch = rr_ptr_reg;
      probe  = rr_ptr_reg;
      for (int k = 0; k < NCH; k++) begin
         if (!hit && eligible[probe]) begin
            hit    = 1'b1;
            hit_ch = probe;
         end
         probe = next_ch(probe);
      end
   end

   // While locked only the owning channel may be served.
   assign pop_ch   = (state_reg == LOCK) ? cur_reg : hit_ch;
   assign pop_word = din_arr[pop_ch];
   assign pop_eoe  = pop_word[DW-1];
   assign wcnt_inc = wcnt_reg + 1'b1;

   // Next-state, grant and word-count logic for the IDLE/LOCK arbiter.
   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      cur_next    = cur_reg;
      wcnt_next   = wcnt_reg;
      ovf_next    = ovf_reg;
      pop_req     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (free && hit) begin
               pop_req   = 1'b1;
               cur_next  = hit_ch;
               wcnt_next = LW'(1);
               if (pop_eoe) begin
                  // Single-word event: no lock, move the pointer past it.
                  rr_ptr_next = next_ch(hit_ch);
               end else begin
                  state_next = LOCK;
               end
            end
         end
         LOCK: begin
            if (free && eligible[cur_reg]) begin
               pop_req = 1'b1;
               if (pop_eoe) begin
                  state_next  = IDLE;
                  rr_ptr_next = next_ch(cur_reg);
                  wcnt_next   = '0;
               end else if (wcnt_inc == LW'(MAXLEN)) begin
                  // Runaway event: release the channel; its remaining words
                  // will be scheduled as fresh events.
                  ovf_next    = 1'b1;
                  state_next  = IDLE;
                  rr_ptr_next = next_ch(cur_reg);
                  wcnt_next   = '0;
               end else begin
                  wcnt_next = wcnt_inc;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Reset also masks the combinational strobe so no word is consumed while held.
   assign pop_en = pop_req && init_;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_pop
         assign pop_vec[gi] = pop_en && (pop_ch == CW'(gi));
      end
   endgenerate

   // Arbiter state, pointer, counters and blanking mask.
   always_ff @(posedge clk or negedge init_) begin
      if (!init_) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         cur_reg    <= '0;
         wcnt_reg   <= '0;
         ovf_reg    <= 1'b0;
         blank_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         cur_reg    <= cur_next;
         wcnt_reg   <= wcnt_next;
         ovf_reg    <= ovf_next;
         blank_reg  <= pop_vec;
      end
   end

   // Output register: load on a pop (overrides a drain), otherwise drain on accept.
   always_ff @(posedge clk or negedge init_) begin
      if (!init_) begin
         dout_reg     <= '0;
         dout_vld_reg <= 1'b0;
         dout_ch_reg  <= '0;
      end else if (pop_en) begin
         dout_reg     <= pop_word;
         dout_ch_reg  <= pop_ch;
         dout_vld_reg <= 1'b1;
      end else if (dout_vld_reg && bus.dout_rdy) begin
         dout_vld_reg <= 1'b0;
      end
   end

`ifdef X6FF_RR_SCHED_STATS_EN
   // Per-channel saturating counts of completed events (EOE word popped).
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_stats
         logic [15:0] evcnt_reg;

         // Count an event when this channel's EOE word is consumed.
         always_ff @(posedge clk or negedge init_) begin
            if (!init_) begin
               evcnt_reg <= '0;
            end else if (pop_vec[gi] && pop_eoe && (evcnt_reg != 16'hFFFF)) begin
               evcnt_reg <= evcnt_reg + 16'd1;
            end
         end

         assign evcnt[gi*16 +: 16] = evcnt_reg;
      end
   endgenerate
`endif

   assign bus.pop      = pop_vec;
   assign bus.dout     = dout_reg;
   assign bus.dout_vld = dout_vld_reg;
   assign bus.dout_ch  = dout_ch_reg;
   assign ovf          = ovf_reg;
   assign busy         = (state_reg == LOCK);

endmodule

// File: tb/tb_x6ff_rr_sched.sv
// tb_x6ff_rr_sched: directed bench for the round-robin event scheduler.
// A small FIFO model per channel feeds pok/din and consumes on pop; the
// stimulus pushes the hand-ordered expected output words into a scoreboard
// queue and a monitor compares every accepted output word against it.
module tb_x6ff_rr_sched;

   localparam int NCH = 6;
   localparam int DW  = 32;

   logic clk   = 1'b0;
   logic init_ = 1'b0;
   logic ovf;
   logic busy;
`ifdef X6FF_RR_SCHED_STATS_EN
   logic [NCH*16-1:0] evcnt;
`endif

   x6ff_rr_sched_if #(.NCH(NCH), .DW(DW)) bus ();

   x6ff_rr_sched #(
      .NCH(NCH), .DW(DW), .MAXLEN(256), .LW(9)
   ) dut (
      .clk   (clk),
      .init_ (init_),
      .bus   (bus),
      .ovf   (ovf),
      .busy  (busy)
`ifdef X6FF_RR_SCHED_STATS_EN
      ,
      .evcnt (evcnt)
`endif
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // channel FIFO model
   logic [DW-1:0] mem [NCH][300];
   int            head [NCH];
   int            tail [NCH];
   logic [NCH-1:0] pop_s;

   // scoreboard: {ch[2:0], word[31:0]}
   logic [34:0] exp_q [$];
   logic [34:0] mon_e;

   logic [5:0] t3_pop  [8] = '{6'h04, 6'h00, 6'h04, 6'h00, 6'h04, 6'h00, 6'h04, 6'h08};
   logic       t3_busy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   function automatic logic [DW-1:0] mkw(input int ch, input int idx, input bit eoe);
      logic [DW-1:0] w;
      w = {eoe, 7'd0, 8'(ch), 16'(idx)};
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic enq(input int ch, input int idx, input bit eoe);
      mem[ch][tail[ch]] = mkw(ch, idx, eoe);
      tail[ch]++;
   endtask

   task automatic expect_word(input int ch, input int idx, input bit eoe);
      exp_q.push_back({3'(ch), mkw(ch, idx, eoe)});
   endtask

   // FIFO model: consume on the pop seen before the edge, then present the next word.
   always begin
      @(negedge clk);
      pop_s = bus.pop;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
         if (pop_s[i] && head[i] != tail[i]) head[i]++;
      end
      #1;
      for (int i = 0; i < NCH; i++) begin
         bus.pok[i] = (head[i] != tail[i]);
         bus.din[i*DW +: DW] = (head[i] != tail[i]) ? mem[i][head[i]] : '0;
      end
   end

   // Monitor: every accepted output word is checked against the scoreboard.
   always @(negedge clk) begin
      if (init_ && bus.dout_vld && bus.dout_rdy) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_word: got ch=%0d data=%08h, required no word", bus.dout_ch, bus.dout);
         end else begin
            mon_e = exp_q.pop_front();
            $display("xfer ch=%0d data=%08h", bus.dout_ch, bus.dout);
            chk("dout_ch", 64'(bus.dout_ch), 64'(mon_e[34:32]));
            chk("dout", 64'(bus.dout), 64'(mon_e[31:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bus.pok      = '0;
      bus.din      = '0;
      bus.dout_rdy = 1'b1;

      // ---- reset values, then idle with no pok
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pop", 64'(bus.pop), 64'h0);
      chk("rst_dout", 64'(bus.dout), 64'h0);
      chk("rst_vld", 64'(bus.dout_vld), 64'h0);
      chk("rst_ch", 64'(bus.dout_ch), 64'h0);
      chk("rst_ovf", 64'(ovf), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      init_ = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle_pop", 64'(bus.pop), 64'h0);
         chk("idle_vld", 64'(bus.dout_vld), 64'h0);
         chk("idle_ovf", 64'(ovf), 64'h0);
         chk("idle_busy", 64'(busy), 64'h0);
      end

      // ---- all channels, single-word events: strict rotation 0..5
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < NCH; c++) enq(c, r, 1'b1);
      for (int k = 0; k < 12; k++) expect_word(k % 6, k / 6, 1'b1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("rr_pop", 64'(bus.pop), 64'(1) << (k % 6));
      end
      repeat (4) @(negedge clk);

      // ---- 4-word event on ch2 with ch3 waiting
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         enq(2, i, i == 3);
         expect_word(2, i, i == 3);
      end
      enq(3, 0, 1'b1);
      expect_word(3, 0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("lock_pop", 64'(bus.pop), 64'(t3_pop[k]));
         chk("lock_busy", 64'(busy), 64'(t3_busy[k]));
      end
      repeat (4) @(negedge clk);

      // ---- backpressure
      @(posedge clk);
      #1;
      enq(1, 0, 1'b1);
      enq(1, 1, 1'b1);
      expect_word(1, 0, 1'b1);
      expect_word(1, 1, 1'b1);
      @(negedge clk);
      chk("bp_first_pop", 64'(bus.pop), 64'h02);
      @(posedge clk);
      #1;
      bus.dout_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_pop", 64'(bus.pop), 64'h0);
         chk("bp_dout", 64'(bus.dout), 64'(mkw(1, 0, 1'b1)));
         chk("bp_vld", 64'(bus.dout_vld), 64'h1);
      end
      @(posedge clk);
      #1;
      bus.dout_rdy = 1'b1;
      @(negedge clk);
      chk("bp_release_pop", 64'(bus.pop), 64'h02);
      repeat (4) @(negedge clk);

      // ---- runaway event on ch0, ch1 waiting
      @(posedge clk);
      #1;
      for (int i = 0; i < 258; i++) enq(0, i, i == 257);
      enq(1, 0, 1'b1);
      for (int i = 0; i < 256; i++) expect_word(0, i, 1'b0);
      expect_word(1, 0, 1'b1);
      expect_word(0, 256, 1'b0);
      expect_word(0, 257, 1'b1);
      cnt = 0;
      for (int c = 0; c < 1200 && cnt < 256; c++) begin
         @(negedge clk);
         if (bus.pop[0]) cnt++;
      end
      chk("ovf_pop_count", 64'(cnt), 64'd256);
      chk("ovf_before", 64'(ovf), 64'h0);
      chk("ovf_busy_before", 64'(busy), 64'h1);
      @(negedge clk);
      chk("ovf_after", 64'(ovf), 64'h1);
      chk("ovf_busy_after", 64'(busy), 64'h0);
      chk("ovf_next_pop", 64'(bus.pop), 64'h02);
      repeat (10) @(negedge clk);
      chk("ovf_sticky", 64'(ovf), 64'h1);
      chk("ovf_end_busy", 64'(busy), 64'h0);

      // ---- reset in the middle of a ch4 event
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         enq(4, i, i == 5);
         expect_word(4, i, i == 5);
      end
      @(negedge clk);
      chk("r_pop0", 64'(bus.pop), 64'h10);
      @(negedge clk);
      chk("r_pop1", 64'(bus.pop), 64'h00);
      chk("r_busy1", 64'(busy), 64'h1);
      @(negedge clk);
      chk("r_pop2", 64'(bus.pop), 64'h10);
      @(posedge clk);
      #1;
      init_ = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      exp_q.delete();
      enq(2, 7, 1'b1);
      enq(5, 7, 1'b1);
      expect_word(2, 7, 1'b1);
      expect_word(5, 7, 1'b1);
      #1;
      chk("r_async_busy", 64'(busy), 64'h0);
      chk("r_async_vld", 64'(bus.dout_vld), 64'h0);
      chk("r_async_pop", 64'(bus.pop), 64'h0);
      chk("r_async_ovf", 64'(ovf), 64'h0);
      @(posedge clk);
      #1;
      init_ = 1'b1;
      @(negedge clk);
      chk("r_first_grant", 64'(bus.pop), 64'h04);
      @(negedge clk);
      chk("r_second_grant", 64'(bus.pop), 64'h20);
      repeat (6) @(negedge clk);
      chk("scoreboard_left", 64'(exp_q.size()), 64'h0);
`ifdef X6FF_RR_SCHED_STATS_EN
      chk("evcnt_ch2", 64'(evcnt[2*16 +: 16]), 64'd1);
      chk("evcnt_ch4", 64'(evcnt[4*16 +: 16]), 64'd0);
      chk("evcnt_ch5", 64'(evcnt[5*16 +: 16]), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
